// File: rtl/csa8_pkg.sv
// Shared width constants for the carry-select adder.
package csa8_pkg;

    localparam int unsigned CSA_W = 8;
    localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/csa8_rca4.sv
// 4-bit ripple-carry adder built from four full adders.
module rca4
    import csa8_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    // Full-adder chain; carry ripples from bit 0 upward.
    always_comb begin
        logic [NIB_W:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[NIB_W];
    end

endmodule

// File: rtl/csa8.sv
// 8-bit carry-select adder with registered sum and carry-out.
// Upper nibble is precomputed for both carry-in values; the low-nibble
// carry picks one, keeping the ripple chain only four bits deep.
module csa8
    import csa8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CSA_W-1:0] a,
    input  logic [CSA_W-1:0] b,
    input  logic             cin,
    output logic [CSA_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] s_lo;
    logic             c4;
    logic [NIB_W-1:0] s_hi0;
    logic             c8_0;
    logic [NIB_W-1:0] s_hi1;
    logic             c8_1;
    logic [NIB_W:0]   hi_sel;
    logic [CSA_W-1:0] sum_n;
    logic             cout_n;

    rca4 u_lo (
        .a  (a[NIB_W-1:0]),
        .b  (b[NIB_W-1:0]),
        .ci (cin),
        .s  (s_lo),
        .co (c4)
    );

    rca4 u_hi0 (
        .a  (a[CSA_W-1:NIB_W]),
        .b  (b[CSA_W-1:NIB_W]),
        .ci (1'b0),
        .s  (s_hi0),
        .co (c8_0)
    );

    rca4 u_hi1 (
        .a  (a[CSA_W-1:NIB_W]),
        .b  (b[CSA_W-1:NIB_W]),
        .ci (1'b1),
        .s  (s_hi1),
        .co (c8_1)
    );

    // Select the upper-nibble result using the low-nibble carry.
    always_comb begin
        hi_sel = c4 ? {c8_1, s_hi1} : {c8_0, s_hi0};
        sum_n  = {hi_sel[NIB_W-1:0], s_lo};
        cout_n = hi_sel[NIB_W];
    end

    // Result register, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_n;
            cout <= cout_n;
        end
    end

endmodule

// File: tb/tb_csa8.sv
// Directed and sweep bench for the registered carry-select adder.
module tb_csa8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    int pass_cnt;
    int total_cnt;

    csa8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands, clock one edge, sample 1 time unit later.
    task automatic drive_and_clock(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b1;
        #2;
        total_cnt++;
        if ({cout, sum} !== 9'h000)
            $display("FAIL reset_async: got cout=%b sum=%h want cout=0 sum=00", cout, sum);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== 9'h000)
            $display("FAIL reset_hold: got cout=%b sum=%h want cout=0 sum=00", cout, sum);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_clock(8'h01, 8'hE2, 1'b0);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'hE3})
            $display("FAIL first_op: got cout=%b sum=%h want cout=0 sum=e3", cout, sum);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        drive_and_clock(8'h01, 8'h02, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'h04})
            $display("FAIL basic_01_02_1: got cout=%b sum=%h want cout=0 sum=04", cout, sum);
        else pass_cnt++;
        drive_and_clock(8'h11, 8'hE2, 1'b0);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'hF3})
            $display("FAIL basic_11_e2_0: got cout=%b sum=%h want cout=0 sum=f3", cout, sum);
        else pass_cnt++;
    endtask

    task automatic test_nibble_carry();
        drive_and_clock(8'h1D, 8'h02, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'h20})
            $display("FAIL nib_1d_02_1: got cout=%b sum=%h want cout=0 sum=20", cout, sum);
        else pass_cnt++;
        drive_and_clock(8'hB1, 8'h3A, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'hEC})
            $display("FAIL nib_b1_3a_1: got cout=%b sum=%h want cout=0 sum=ec", cout, sum);
        else pass_cnt++;
        drive_and_clock(8'h0F, 8'h01, 1'b0);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'h10})
            $display("FAIL nib_0f_01_0: got cout=%b sum=%h want cout=0 sum=10", cout, sum);
        else pass_cnt++;
    endtask

    task automatic test_carry_out();
        drive_and_clock(8'hC1, 8'hB2, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b1, 8'h74})
            $display("FAIL cout_c1_b2_1: got cout=%b sum=%h want cout=1 sum=74", cout, sum);
        else pass_cnt++;
        drive_and_clock(8'hFF, 8'hFF, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b1, 8'hFF})
            $display("FAIL cout_ff_ff_1: got cout=%b sum=%h want cout=1 sum=ff", cout, sum);
        else pass_cnt++;
        drive_and_clock(8'hFF, 8'h00, 1'b1);
        total_cnt++;
        if ({cout, sum} !== {1'b1, 8'h00})
            $display("FAIL cout_ff_00_1: got cout=%b sum=%h want cout=1 sum=00", cout, sum);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive_and_clock(8'hC1, 8'h3A, 1'b0);
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'hFB})
            $display("FAIL b2b_first: got cout=%b sum=%h want cout=0 sum=fb", cout, sum);
        else pass_cnt++;
        // Operands change mid-cycle; the registered result must not move.
        a   = 8'h01;
        b   = 8'h7A;
        cin = 1'b1;
        #2;
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'hFB})
            $display("FAIL b2b_hold: got cout=%b sum=%h want cout=0 sum=fb", cout, sum);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== {1'b0, 8'h7C})
            $display("FAIL b2b_second: got cout=%b sum=%h want cout=0 sum=7c", cout, sum);
        else pass_cnt++;
        // Load a nonzero carry, then reset between edges.
        drive_and_clock(8'hFF, 8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({cout, sum} !== 9'h000)
            $display("FAIL midstream_reset: got cout=%b sum=%h want cout=0 sum=00", cout, sum);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({cout, sum} !== 9'h000)
            $display("FAIL midstream_hold: got cout=%b sum=%h want cout=0 sum=00", cout, sum);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [8:0] exp;
        int         errs;
        errs = 0;
        // All a against 16 spread b values, both carry-ins.
        for (int bi = 0; bi < 256; bi += 17) begin
            for (int ai = 0; ai < 256; ai++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    drive_and_clock(8'(ai), 8'(bi), 1'(ci));
                    exp = 9'(ai) + 9'(bi) + 9'(ci);
                    total_cnt++;
                    if ({cout, sum} !== exp) begin
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep a=%h b=%h cin=%0d: got %h want %h",
                                     8'(ai), 8'(bi), ci, {cout, sum}, exp);
                    end else pass_cnt++;
                end
            end
        end
        // Random operands.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive_and_clock(ra, rb, rc);
            exp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            total_cnt++;
            if ({cout, sum} !== exp) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random a=%h b=%h cin=%b: got %h want %h",
                             ra, rb, rc, {cout, sum}, exp);
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        test_reset();
        test_basic();
        test_nibble_carry();
        test_carry_out();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
